// File: rtl/add_round_key_seq.sv
// AddRoundKey stage for an iterative AES-128 encryptor.
// The key schedule is expanded one round key at a time, and the cipher key is kept for the next block.
module add_round_key_seq #(
  parameter  int unsigned NR = 10,
  localparam int unsigned DW = 128,
  localparam int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_load,
  input  logic [DW-1:0] key_in,
  output logic          key_valid,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [RW-1:0] out_round,
  output logic          busy
);

  typedef enum logic [1:0] {NOKEY, READY, EXPAND} state_t;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [RW-1:0] r);
    logic [7:0] c;
    c = 8'h00;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  state_t        state_q, state_d;
  logic [RW-1:0] round_q, round_d;
  logic [DW-1:0] rk_q, rk_d, saved_q, saved_d;
  logic [DW-1:0] out_data_d;
  logic [RW-1:0] out_round_d;
  logic          out_valid_d, key_valid_d;
  logic          accept;

  // Next round key from the current one; round_q already holds the new round index.
  logic [31:0] w0, w1, w2, w3, temp, w4, w5, w6, w7;
  logic [DW-1:0] next_rk;
  assign w0      = rk_q[127:96];
  assign w1      = rk_q[95:64];
  assign w2      = rk_q[63:32];
  assign w3      = rk_q[31:0];
  assign temp    = sub_word({w3[23:0], w3[31:24]}) ^ {rcon(round_q), 24'h000000};
  assign w4      = w0 ^ temp;
  assign w5      = w4 ^ w1;
  assign w6      = w5 ^ w2;
  assign w7      = w6 ^ w3;
  assign next_rk = {w4, w5, w6, w7};

  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    rk_d        = rk_q;
    saved_d     = saved_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_round_d = out_round;
    key_valid_d = key_valid;
    in_ready    = 1'b0;

    if (state_q == READY) in_ready = !out_valid || out_ready;
    // A key load wins over any input offered in the same cycle.
    if (key_load) in_ready = 1'b0;
    accept = in_valid && in_ready;

    if (out_valid && out_ready) out_valid_d = 1'b0;

    if (state_q == EXPAND) begin
      rk_d    = next_rk;
      state_d = READY;
    end

    if (accept) begin
      out_data_d  = in_data ^ rk_q;
      out_round_d = round_q;
      out_valid_d = 1'b1;
      if (round_q < RW'(NR)) begin
        round_d = round_q + 4'd1;
        state_d = EXPAND;
      end else begin
        // Last round: restore the cipher key so the next block starts at once.
        rk_d    = saved_q;
        round_d = '0;
        state_d = READY;
      end
    end

    if (key_load) begin
      rk_d        = key_in;
      saved_d     = key_in;
      round_d     = '0;
      state_d     = READY;
      key_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= NOKEY;
      round_q   <= '0;
      rk_q      <= '0;
      saved_q   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_round <= '0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      round_q   <= round_d;
      rk_q      <= rk_d;
      saved_q   <= saved_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_round <= out_round_d;
      key_valid <= key_valid_d;
      busy      <= (round_d != '0);
    end
  end

endmodule

// File: tb/tb_add_round_key_seq.sv
// Bench for add_round_key_seq: FIPS-197 key schedule model built from GF(2^8) arithmetic,
// a per-cycle output scoreboard and directed vectors from the AES-128 example.
module tb_add_round_key_seq;
  localparam int unsigned NR = 10;
  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_load = 1'b0;
  logic [127:0] key_in = '0;
  logic         key_valid;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic [3:0]   out_round;
  logic         busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_round_key_seq #(.NR(NR)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .key_valid(key_valid),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_round(out_round), .busy(busy)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // GF(2^8) helpers: S-box derived as multiplicative inverse plus affine map.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sb(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(a, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [127:0] mrk [0:NR];

  task automatic expand_key(input logic [127:0] k);
    logic [31:0] w [0:4*NR+3];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 4*(NR+1); i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb(t[31:24]), sb(t[23:16]), sb(t[15:8]), sb(t[7:0])} ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= NR; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Scoreboard: model of the handshake and of outputs still owed downstream.
  typedef struct packed { logic [127:0] d; logic [3:0] r; } exp_t;
  exp_t        q[$];
  logic        m_key = 1'b0;
  logic        m_exp = 1'b0;
  int unsigned m_round = 0;

  always @(negedge clk) begin
    logic exp_ir;
    exp_t e;
    if (rst) begin
      q.delete();
      m_key = 1'b0;
      m_exp = 1'b0;
      m_round = 0;
    end else begin
      exp_ir = m_key && !m_exp && (q.size() == 0 || out_ready) && !key_load;
      chkb("in_ready", in_ready, exp_ir);
      chkb("out_valid", out_valid, q.size() != 0);
      chkb("key_valid", key_valid, m_key);
      chkb("busy", busy, m_round != 0);
      if (q.size() != 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_round", 128'(out_round), 128'(q[0].r));
        if (out_ready) void'(q.pop_front());
      end
      if (key_load) begin
        expand_key(key_in);
        m_key = 1'b1;
        m_round = 0;
        m_exp = 1'b0;
      end else if (in_valid && exp_ir) begin
        e.d = in_data ^ mrk[m_round];
        e.r = 4'(m_round);
        q.push_back(e);
        if (m_round < NR) begin
          m_round++;
          m_exp = 1'b1;
        end else begin
          m_round = 0;
          m_exp = 1'b0;
        end
      end else begin
        m_exp = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k);
    key_in = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  // Offer one state and return 1 time unit after the accepting edge.
  task automatic feed(input logic [127:0] d);
    int n;
    logic ok;
    n = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = in_ready;
      tick();
      n++;
    end
    in_valid = 1'b0;
    chkb("feed_accept", ok, 1'b1);
  endtask

  task automatic feed_chk(input string name, input logic [127:0] d, input logic [127:0] exp,
                          input logic [3:0] r);
    feed(d);
    chk(name, out_data, exp);
    chk({name, "_round"}, 128'(out_round), 128'(r));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [127:0] b, c, d;
    repeat (3) tick();
    chkb("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_round", 128'(out_round), '0);
    chkb("rst_key_valid", key_valid, 1'b0);
    chkb("rst_in_ready", in_ready, 1'b0);
    chkb("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Zero states expose the round keys directly.
    load_key(K1);
    chk("model_rk1", mrk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_rk10", mrk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int r = 0; r <= 10; r++) begin
      feed(128'h0);
      chk("zero_round", 128'(out_round), 128'(r));
      if (r == 0) begin
        chk("zero_rk0", out_data, K1);
        chkb("busy_mid", busy, 1'b1);
      end
      if (r == 1) chk("zero_rk1", out_data, 128'ha0fafe1788542cb123a339392a6c7605);
      if (r == 10) begin
        chk("zero_rk10", out_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        chkb("busy_wrap", busy, 1'b0);
      end
    end

    // FIPS-197 example block.
    feed_chk("fips_r0", 128'h3243f6a8885a308d313198a2e0370734,
             128'h193de3bea0f4e22b9ac68d2ae9f84808, 4'd0);
    feed_chk("fips_r1", 128'h046681e5e0cb199a48f8d37a2806264c,
             128'ha49c7ff2689f352b6b5bea43026a5049, 4'd1);
    for (int r = 2; r <= 10; r++) feed({16{8'(r * 17)}});

    // Saved key restored for the next block without reload.
    c = 128'h00112233445566778899aabbccddeeff;
    feed_chk("restore_r0", c, c ^ K1, 4'd0);

    // Backpressure: one output held, next input blocked until drain.
    b = 128'hfedcba98765432100123456789abcdef;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    repeat (5) begin
      @(negedge clk);
      chkb("stall_in_ready", in_ready, 1'b0);
      chk("stall_out_data", out_data, c ^ K1);
    end
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chkb("drain_in_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chkb("drain_out_valid", out_valid, 1'b1);
    chk("drain_out_data", out_data, b ^ 128'ha0fafe1788542cb123a339392a6c7605);
    chk("drain_out_round", 128'(out_round), 128'd1);

    // Key load colliding with an input at round 4.
    feed(128'h11);
    feed(128'h22);
    tick();
    chkb("busy_r4", busy, 1'b1);
    d = 128'h00112233445566778899aabbccddeeff;
    key_in = K2;
    key_load = 1'b1;
    in_valid = 1'b1;
    in_data = d;
    @(negedge clk);
    chkb("keyload_in_ready", in_ready, 1'b0);
    tick();
    key_load = 1'b0;
    chkb("keyload_busy", busy, 1'b0);
    feed_chk("newkey_r0", d, 128'h00102030405060708090a0b0c0d0e0f0, 4'd0);
    feed(128'h33);

    // Asynchronous reset during the expand cycle.
    rst = 1'b1;
    #1;
    chkb("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_data", out_data, '0);
    chk("arst_out_round", 128'(out_round), '0);
    chkb("arst_key_valid", key_valid, 1'b0);
    chkb("arst_in_ready", in_ready, 1'b0);
    chkb("arst_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    in_valid = 1'b1;
    in_data = 128'h44;
    repeat (3) begin
      @(negedge clk);
      chkb("nokey_in_ready", in_ready, 1'b0);
    end
    tick();
    load_key(K1);
    feed_chk("reload_r0", 128'h0, K1, 4'd0);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
